// File: rtl/generic_bus_rr_arbiter.sv
// generic_bus_rr_arbiter
//   Round-robin arbiter that lets NUM_REQ generic-bus requestors share one target.
//   A grant is taken in IDLE (one cycle, no bus activity). It is then held for the whole
//   transaction in ACTIVE until one of three things happens:
//     - the target completes;
//     - the watchdog expires;
//     - the granted requestor abandons its request.
//
// Ports
//   CLK, RST                      clock, synchronous active-high reset
//   req_addr/ren/wen/wdata/byte_en  per-channel request fields (channel i at slice i)
//   req_rdata                     broadcast read data
//   req_busy, req_error           per-channel handshake; only the granted channel sees busy=0
//   bus_addr/ren/wen/wdata/byte_en  target-side request, muxed from the granted channel
//   bus_rdata, bus_busy, bus_error  target-side response
//   grant_id                      granted channel, 0 while idle
module generic_bus_rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
    input  logic [NUM_REQ-1:0]            req_ren,
    input  logic [NUM_REQ-1:0]            req_wen,
    input  logic [NUM_REQ*DATA_W-1:0]     req_wdata,
    input  logic [NUM_REQ*DATA_W/8-1:0]   req_byte_en,
    output logic [DATA_W-1:0]             req_rdata,
    output logic [NUM_REQ-1:0]            req_busy,
    output logic [NUM_REQ-1:0]            req_error,
    output logic [ADDR_W-1:0]             bus_addr,
    output logic                          bus_ren,
    output logic                          bus_wen,
    output logic [DATA_W-1:0]             bus_wdata,
    output logic [DATA_W/8-1:0]           bus_byte_en,
    input  logic [DATA_W-1:0]             bus_rdata,
    input  logic                          bus_busy,
    input  logic                          bus_error,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

    localparam int unsigned BeW  = DATA_W / 8;
    localparam int unsigned GntW = $clog2(NUM_REQ);
    localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT);

    localparam logic [0:0] StIdle   = 1'b0;
    localparam logic [0:0] StActive = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [GntW-1:0] grant_q, grant_d;
    logic [GntW-1:0] ptr_q, ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Round-robin search starting at ptr_q.
    int unsigned     cand;
    logic [GntW-1:0] cand_idx;
    logic [GntW-1:0] pick_idx;
    logic            pick_found;

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand     = (32'(ptr_q) + k) % NUM_REQ;
            cand_idx = GntW'(cand);
            if (!pick_found && (req_ren[cand_idx] || req_wen[cand_idx])) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    // Fields of the granted channel; write wins when ren and wen are both set.
    logic g_ren, g_wen, g_req;
    assign g_wen = req_wen[grant_q];
    assign g_ren = req_ren[grant_q] & ~req_wen[grant_q];
    assign g_req = g_ren | g_wen;

    assign bus_addr    = req_addr[32'(grant_q) * ADDR_W +: ADDR_W];
    assign bus_wdata   = req_wdata[32'(grant_q) * DATA_W +: DATA_W];
    assign bus_byte_en = req_byte_en[32'(grant_q) * BeW +: BeW];
    assign req_rdata   = bus_rdata;

    logic [GntW-1:0] ptr_adv;
    logic            timed_out;
    assign ptr_adv   = (grant_q == GntW'(NUM_REQ - 1)) ? '0 : grant_q + GntW'(1);
    assign timed_out = (TIMEOUT != 0) && (cnt_q == TimeoutCnt);

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        bus_ren   = 1'b0;
        bus_wen   = 1'b0;
        req_busy  = '1;
        req_error = '0;
        grant_id  = grant_q;

        case (state_q)
            StIdle: begin
                if (pick_found) begin
                    state_d = StActive;
                    grant_d = pick_idx;
                end
            end
            StActive: begin
                if (!g_req) begin
                    // Requestor abandoned the transaction: release silently.
                    state_d = StIdle;
                    grant_d = '0;
                    ptr_d   = ptr_adv;
                    cnt_d   = '0;
                end else if (!bus_busy) begin
                    bus_ren            = g_ren;
                    bus_wen            = g_wen;
                    req_busy[grant_q]  = 1'b0;
                    req_error[grant_q] = bus_error;
                    state_d            = StIdle;
                    grant_d            = '0;
                    ptr_d              = ptr_adv;
                    cnt_d              = '0;
                end else if (timed_out) begin
                    // Watchdog: complete with error and withdraw the bus request.
                    req_busy[grant_q]  = 1'b0;
                    req_error[grant_q] = 1'b1;
                    state_d            = StIdle;
                    grant_d            = '0;
                    ptr_d              = ptr_adv;
                    cnt_d              = '0;
                end else begin
                    bus_ren = g_ren;
                    bus_wen = g_wen;
                    cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
            end
        endcase

        // Reset aborts silently, including in the cycle it is asserted.
        if (RST) begin
            bus_ren   = 1'b0;
            bus_wen   = 1'b0;
            req_busy  = '1;
            req_error = '0;
            grant_id  = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            grant_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // A channel must never request a read and a write at the same time.
    a_no_rw_both: assert property (@(posedge CLK) disable iff (RST) (req_ren & req_wen) == '0)
        else $error("generic_bus_rr_arbiter: ren and wen both set on one channel");

endmodule

// File: tb/tb_generic_bus_rr_arbiter.sv
// Bench for generic_bus_rr_arbiter (NUM_REQ=4, TIMEOUT=4).
// Directed cycle table first, then randomized traffic against a transaction-level model.
module tb_generic_bus_rr_arbiter;

    localparam int NR = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int TO = 4;

    logic              CLK = 1'b0;
    logic              RST;
    logic [NR*AW-1:0]  req_addr;
    logic [NR-1:0]     req_ren, req_wen;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR*BW-1:0]  req_byte_en;
    logic [DW-1:0]     req_rdata;
    logic [NR-1:0]     req_busy, req_error;
    logic [AW-1:0]     bus_addr;
    logic              bus_ren, bus_wen;
    logic [DW-1:0]     bus_wdata;
    logic [BW-1:0]     bus_byte_en;
    logic [DW-1:0]     bus_rdata;
    logic              bus_busy, bus_error;
    logic [1:0]        grant_id;

    generic_bus_rr_arbiter #(
        .NUM_REQ (NR),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .req_addr    (req_addr),
        .req_ren     (req_ren),
        .req_wen     (req_wen),
        .req_wdata   (req_wdata),
        .req_byte_en (req_byte_en),
        .req_rdata   (req_rdata),
        .req_busy    (req_busy),
        .req_error   (req_error),
        .bus_addr    (bus_addr),
        .bus_ren     (bus_ren),
        .bus_wen     (bus_wen),
        .bus_wdata   (bus_wdata),
        .bus_byte_en (bus_byte_en),
        .bus_rdata   (bus_rdata),
        .bus_busy    (bus_busy),
        .bus_error   (bus_error),
        .grant_id    (grant_id)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic          rst;
        logic [NR-1:0] ren;
        logic [NR-1:0] wen;
        logic          bbusy;
        logic [NR-1:0] e_busy;
        logic [NR-1:0] e_err;
        logic          e_ren;
        logic          e_wen;
        logic [1:0]    e_gid;
    } vec_t;

    vec_t tbl[$];

    task automatic row(input logic rst, input logic [3:0] ren, input logic [3:0] wen,
                       input logic bb, input logic [3:0] eb, input logic [3:0] ee,
                       input logic er, input logic ew, input logic [1:0] eg);
        vec_t v;
        v.rst = rst; v.ren = ren; v.wen = wen; v.bbusy = bb;
        v.e_busy = eb; v.e_err = ee; v.e_ren = er; v.e_wen = ew; v.e_gid = eg;
        tbl.push_back(v);
    endtask

    // ---------------- reference model ----------------
    int owner, ptr, cnt;            // owner = -1 when no transaction is in progress
    int nx_owner, nx_ptr, nx_cnt;
    logic [NR-1:0] e_busy, e_err;
    logic          e_ren, e_wen, e_done, e_tout;
    logic [1:0]    e_gid;

    task automatic model_eval();
        e_busy = '1; e_err = '0; e_ren = 1'b0; e_wen = 1'b0; e_gid = 2'd0;
        e_done = 1'b0; e_tout = 1'b0;
        nx_owner = owner; nx_ptr = ptr; nx_cnt = cnt;
        if (RST) begin
            nx_owner = -1; nx_ptr = 0; nx_cnt = 0;
        end else if (owner < 0) begin
            for (int k = 0; k < NR; k++) begin
                automatic int c = (ptr + k) % NR;
                if ((req_ren[c] || req_wen[c]) && nx_owner < 0) nx_owner = c;
            end
        end else begin
            e_gid = 2'(owner);
            e_wen = req_wen[owner];
            e_ren = req_ren[owner] & ~req_wen[owner];
            if (!(e_ren || e_wen)) begin
                nx_owner = -1; nx_ptr = (owner + 1) % NR; nx_cnt = 0;
            end else if (!bus_busy) begin
                e_busy[owner] = 1'b0; e_err[owner] = bus_error; e_done = 1'b1;
                nx_owner = -1; nx_ptr = (owner + 1) % NR; nx_cnt = 0;
            end else if (cnt == TO) begin
                e_busy[owner] = 1'b0; e_err[owner] = 1'b1; e_tout = 1'b1;
                e_ren = 1'b0; e_wen = 1'b0;
                nx_owner = -1; nx_ptr = (owner + 1) % NR; nx_cnt = 0;
            end else begin
                nx_cnt = cnt + 1;
            end
        end
    endtask

    initial begin
        RST = 1'b1; req_ren = '0; req_wen = '0;
        bus_busy = 1'b1; bus_error = 1'b0; bus_rdata = 32'hDEADBEEF;
        for (int i = 0; i < NR; i++) begin
            req_addr[i*AW +: AW]    = 32'h100 + 32'(i) * 32'h10;
            req_wdata[i*DW +: DW]   = 32'hCAFE0000 + 32'(i);
            req_byte_en[i*BW +: BW] = 4'(i + 1);
        end

        // reset with all channels reading
        for (int i = 0; i < 3; i++) row(1, 4'hF, 4'h0, 1, 4'hF, 4'h0, 0, 0, 0);
        // single read, two busy cycles then done
        row(0, 4'h1, 4'h0, 1, 4'hF, 4'h0, 0, 0, 0);
        row(0, 4'h1, 4'h0, 1, 4'hF, 4'h0, 1, 0, 0);
        row(0, 4'h1, 4'h0, 1, 4'hF, 4'h0, 1, 0, 0);
        row(0, 4'h1, 4'h0, 0, 4'hE, 4'h0, 1, 0, 0);
        // move pointer to 3, then ch1+ch2 together: ch1 first via wrap
        row(0, 4'h4, 4'h0, 1, 4'hF, 4'h0, 0, 0, 0);
        row(0, 4'h4, 4'h0, 0, 4'hB, 4'h0, 1, 0, 2);
        row(0, 4'h6, 4'h0, 1, 4'hF, 4'h0, 0, 0, 0);
        row(0, 4'h6, 4'h0, 0, 4'hD, 4'h0, 1, 0, 1);
        row(0, 4'h4, 4'h0, 1, 4'hF, 4'h0, 0, 0, 0);
        row(0, 4'h4, 4'h0, 0, 4'hB, 4'h0, 1, 0, 2);
        // watchdog on a stuck write from ch3
        row(0, 4'h0, 4'h8, 1, 4'hF, 4'h0, 0, 0, 0);
        for (int i = 0; i < 4; i++) row(0, 4'h0, 4'h8, 1, 4'hF, 4'h0, 0, 1, 3);
        row(0, 4'h0, 4'h8, 1, 4'h7, 4'h8, 0, 0, 3);
        row(0, 4'h0, 4'h0, 1, 4'hF, 4'h0, 0, 0, 0);
        // reset in the middle of a write: no completion, then retried
        row(0, 4'h0, 4'h1, 1, 4'hF, 4'h0, 0, 0, 0);
        row(0, 4'h0, 4'h1, 1, 4'hF, 4'h0, 0, 1, 0);
        row(1, 4'h0, 4'h1, 0, 4'hF, 4'h0, 0, 0, 0);
        row(0, 4'h0, 4'h1, 1, 4'hF, 4'h0, 0, 0, 0);
        row(0, 4'h0, 4'h1, 0, 4'hE, 4'h0, 0, 1, 0);
        row(0, 4'h0, 4'h0, 1, 4'hF, 4'h0, 0, 0, 0);
        // ch1 drops its request mid-transaction; pointer still advances past it
        row(0, 4'h2, 4'h0, 1, 4'hF, 4'h0, 0, 0, 0);
        row(0, 4'h2, 4'h0, 1, 4'hF, 4'h0, 1, 0, 1);
        row(0, 4'h0, 4'h0, 0, 4'hF, 4'h0, 0, 0, 1);
        row(0, 4'h3, 4'h0, 1, 4'hF, 4'h0, 0, 0, 0);
        row(0, 4'h3, 4'h0, 0, 4'hE, 4'h0, 1, 0, 0);
        row(0, 4'h2, 4'h0, 1, 4'hF, 4'h0, 0, 0, 0);
        row(0, 4'h2, 4'h0, 0, 4'hD, 4'h0, 1, 0, 1);
        row(0, 4'h0, 4'h0, 1, 4'hF, 4'h0, 0, 0, 0);
        // all four request continuously, single-cycle target: 0,1,2,3,0
        row(1, 4'hF, 4'h0, 0, 4'hF, 4'h0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            row(0, 4'hF, 4'h0, 0, 4'hF, 4'h0, 0, 0, 0);
            row(0, 4'hF, 4'h0, 0, ~(4'b0001 << (i % 4)), 4'h0, 1, 0, 2'(i % 4));
        end

        foreach (tbl[n]) begin
            @(posedge CLK); #1;
            RST = tbl[n].rst; req_ren = tbl[n].ren; req_wen = tbl[n].wen;
            bus_busy = tbl[n].bbusy;
            #3;
            chk($sformatf("tbl%0d req_busy", n), req_busy, tbl[n].e_busy);
            chk($sformatf("tbl%0d req_error", n), req_error, tbl[n].e_err);
            chk($sformatf("tbl%0d bus_ren", n), bus_ren, tbl[n].e_ren);
            chk($sformatf("tbl%0d bus_wen", n), bus_wen, tbl[n].e_wen);
            chk($sformatf("tbl%0d grant_id", n), grant_id, tbl[n].e_gid);
            if (tbl[n].e_ren || tbl[n].e_wen)
                chk($sformatf("tbl%0d bus_addr", n), bus_addr,
                    32'h100 + 32'(tbl[n].e_gid) * 32'h10);
            if (tbl[n].e_wen)
                chk($sformatf("tbl%0d bus_wdata", n), bus_wdata,
                    32'hCAFE0000 + 32'(tbl[n].e_gid));
            if (tbl[n].e_busy != 4'hF && tbl[n].e_err == 4'h0)
                chk($sformatf("tbl%0d req_rdata", n), req_rdata, 32'hDEADBEEF);
        end

        // ---------------- randomized traffic ----------------
        owner = -1; ptr = 0; cnt = 0;
        req_ren = '0; req_wen = '0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge CLK);
            if (cyc > 0) begin
                owner = nx_owner; ptr = nx_ptr; cnt = nx_cnt;
            end
            #1;
            RST = (cyc == 0) || ($urandom_range(0, 199) == 0);
            for (int i = 0; i < NR; i++) begin
                if (!req_ren[i] && !req_wen[i] && $urandom_range(0, 3) == 0) begin
                    if ($urandom_range(0, 1) == 1) req_wen[i] = 1'b1;
                    else                           req_ren[i] = 1'b1;
                    req_addr[i*AW +: AW]    = $urandom;
                    req_wdata[i*DW +: DW]   = $urandom;
                    req_byte_en[i*BW +: BW] = 4'($urandom);
                end
            end
            bus_busy  = ($urandom_range(0, 99) < 55);
            bus_error = ($urandom_range(0, 3) == 0);
            bus_rdata = $urandom;
            #3;
            model_eval();
            chk("rnd req_busy", req_busy, e_busy);
            chk("rnd req_error", req_error, e_err);
            chk("rnd bus_ren", bus_ren, e_ren);
            chk("rnd bus_wen", bus_wen, e_wen);
            chk("rnd grant_id", grant_id, e_gid);
            if (e_ren || e_wen) begin
                chk("rnd bus_addr", bus_addr, req_addr[32'(e_gid)*AW +: AW]);
                chk("rnd bus_byte_en", bus_byte_en, req_byte_en[32'(e_gid)*BW +: BW]);
                if (e_wen) chk("rnd bus_wdata", bus_wdata, req_wdata[32'(e_gid)*DW +: DW]);
            end
            if (e_done) chk("rnd req_rdata", req_rdata, bus_rdata);
            // requestors retire once their completion has been seen
            for (int i = 0; i < NR; i++) begin
                if (!e_busy[i]) begin
                    req_ren[i] = 1'b0;
                    req_wen[i] = 1'b0;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
